ef_smsdac_lfsr10_7_chk: RTL
===========================

// Module: ef_smsdac_lfsr10_7_chk
// PURPOSE
// - Receive-side checker for the 10-b, 7-tap dither LFSR stream, the jump-5-states-per-clock generator.
// - Self-synchronises to the 7-b tapped word, then predicts each following word and flags mismatches.
// - Sits on the dither bus, either in the DAC test path or at a scan/observe port.
// - Gives BIST-style proof that the dither source is alive and uncorrupted.
// PARAMETERS
// - LOCK_GOOD  4   consecutive matching words needed in VERIFY before locked=1 (>=1)
// - LOSS_THRESH  3   consecutive mismatches while LOCKED that force a return to SEARCH (>=1)
// - ERR_W  16  width of saturating error counter
// PORTS
// - clk       in   1      system clock, rising edge
// - rst_b     in   1      asynchronous active-low reset
// - en_dith   in   1      sample strobe; r_in is valid (one generator step) when high
// - r_in      in   7      observed tapped word, equal to generator q[9:3]
// - clr_cnt   in   1      synchronous clear of err_cnt (priority over increment)
// - locked    out  1      state==LOCKED
// - err_pulse out  1      one-cycle pulse, registered, on a mismatch in VERIFY or LOCKED
// - err_cnt   out  ERR_W  saturating count of mismatches seen while LOCKED
// BEHAVIOUR
// - Generator step, next(q): q'[9:5]=q[4:0]^q[7:3]; q'[4:0]=q[9:5]; output word = q[9:3].
// - Reset values: state=SEARCH, s(10b)=0, prev(7b)=0, good/bad counters=0, locked=0, err_pulse=0, err_cnt=0.
// - All state advances only on cycles with en_dith=1. Other cycles hold everything except err_pulse, which returns to 0.
// - SEARCH: prev<=r_in; go to ACQ.
// - ACQ: candidate c={r_in, prev[4:2]}. Check A: r_in[1:0]==prev[6:5]. Check B: r_in[6:5]^prev[4:3]==prev[1:0].
//   - If A and B pass and c!=0: s<=c, good<=0, go to VERIFY.
//   - Otherwise: prev<=r_in and stay in ACQ (sliding window). No err_pulse is raised.
// - VERIFY: p=next(s); s<=p; if r_in==p[9:3] then good++, else go to SEARCH and raise err_pulse.
//   - When good reaches LOCK_GOOD, go to LOCKED and clear bad.
// - LOCKED: p=next(s); s<=p (the prediction free-runs and is NOT reloaded from r_in).
//   - On a match: bad<=0.
//   - On a mismatch: err_pulse=1 next cycle, err_cnt++ (saturates at 2^ERR_W-1), bad++.
//   - When bad==LOSS_THRESH: go to SEARCH, locked drops on the same edge.
// - locked is registered; it rises the cycle after the LOCK_GOOD-th match and equals (state==LOCKED).
// - Latency: err_pulse and the err_cnt update appear one clk after the en_dith sample that mismatched.
// - clr_cnt together with a mismatch in the same cycle: err_cnt=0. The mismatch is dropped from the count; err_pulse still fires.
// - An all-zero candidate is rejected (the generator cannot reach it), so the checker never locks to a stuck-at-0 bus.
// - A stuck-at-1 bus fails check B, so the checker never locks to it either.
// - rst_b asserted mid-lock: immediate async return to reset values; err_cnt is lost.
// - Counters good and bad are sized $clog2(max(LOCK_GOOD,LOSS_THRESH)+1).
// STRUCTURE
// - Shared package ef_smsdac_pkg holds:
//   - localparam LFSR_W=10 and TAP_W=7;
//   - function lfsr10_step(q) returning the 5-state jump, reused by the generator and this block;
//   - state enum {SEARCH, ACQ, VERIFY, LOCKED}.
// - One sub-module ef_smsdac_satcnt (ERR_W-b saturating counter with sync clear, async active-low reset) holds err_cnt.
// - Everything else is a single always block plus the next-state logic.
// TESTING
// - Reference sequence from generator reset (q=10'h001): r = 7'h00, 7'h04, 7'h10, ...
// - T1 clean lock: drive the generator sequence from reset with en_dith=1 -> locked=1 after 2+LOCK_GOOD strobes; err_cnt=0 for 1000 words.
// - T2 single bit flip: while locked, replace one word with r^7'h01 -> one err_pulse, err_cnt=1, locked stays 1, next word matches.
// - T3 loss: while locked, drive LOSS_THRESH consecutive random mismatching words -> locked=0 on the 3rd, state SEARCH, then relock on a clean stream.
// - T4 stuck bus: r_in=7'h00 held, then r_in=7'h7F held, 100 strobes each -> locked stays 0, err_pulse never fires.
// - T5 strobe gaps: en_dith=1 only every 3rd clk -> same lock time counted in strobes; idle cycles change nothing.
// - T6 saturation and clear: ERR_W=4, 20 mismatches that keep bad<LOSS_THRESH -> err_cnt=4'hF. clr_cnt together with a mismatch -> err_cnt=0. Async rst_b pulse while locked -> all outputs 0 immediately.

Source files
------------

// File: rtl/ef_smsdac_pkg.sv
// Shared definitions for the SMS-DAC dither path: LFSR geometry, the
// 5-states-per-clock jump function and the checker state encoding.
package ef_smsdac_pkg;

    localparam int LFSR_W = 10;
    localparam int TAP_W  = 7;

    typedef enum logic [1:0] {
        SEARCH,
        ACQ,
        VERIFY,
        LOCKED
    } state_e;

    // One generator clock: five single-bit LFSR shifts folded into one step.
    function automatic logic [LFSR_W-1:0] lfsr10_step(input logic [LFSR_W-1:0] q);
        logic [LFSR_W-1:0] n;
        n[9:5] = q[4:0] ^ q[7:3];
        n[4:0] = q[9:5];
        return n;
    endfunction

endpackage

// File: rtl/ef_smsdac_lfsr10_7_chk_if.sv
// Dither-bus observation interface: sample strobe and tapped word in,
// lock/error status out.
interface ef_smsdac_lfsr10_7_chk_if #(
    parameter int ERR_W = 16
);
    import ef_smsdac_pkg::*;

    logic             en_dith;
    logic [TAP_W-1:0] r_in;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en_dith, r_in, clr_cnt,
        input  locked, err_pulse, err_cnt
    );

    modport slave (
        input  en_dith, r_in, clr_cnt,
        output locked, err_pulse, err_cnt
    );

endinterface

// File: rtl/ef_smsdac_satcnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-low reset.
module ef_smsdac_satcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default assigned first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ef_smsdac_lfsr10_7_chk.sv
// Receive-side checker for the 10-b / 7-tap dither LFSR: self-synchronises
// from two consecutive words, then free-runs a prediction and flags mismatches.
module ef_smsdac_lfsr10_7_chk
    import ef_smsdac_pkg::*;
#(
    parameter int LOCK_GOOD   = 4,
    parameter int LOSS_THRESH = 3,
    parameter int ERR_W       = 16
) (
    input logic                     clk,
    input logic                     rst_b,
    ef_smsdac_lfsr10_7_chk_if.slave bus
);

    localparam int CNT_MAX = (LOCK_GOOD > LOSS_THRESH) ? LOCK_GOOD : LOSS_THRESH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   s_q, s_d;
    logic [TAP_W-1:0]    prev_q, prev_d;
    logic [CNT_W-1:0]    good_q, good_d;
    logic [CNT_W-1:0]    bad_q, bad_d;
    logic                err_pulse_q, err_pulse_d;
    logic                cnt_inc;
    logic [ERR_W-1:0]    err_cnt;

    logic [LFSR_W-1:0]   pred;
    logic [LFSR_W-1:0]   cand;
    logic                match;
    logic                chk_a;
    logic                chk_b;

    assign pred  = lfsr10_step(s_q);
    assign match = (bus.r_in == pred[LFSR_W-1:LFSR_W-TAP_W]);

    // prev and r_in are two consecutive words; A and B are the overlap bits
    // the step function fixes, and the candidate is the state behind r_in.
    assign cand  = {bus.r_in, prev_q[4:2]};
    assign chk_a = (bus.r_in[1:0] == prev_q[6:5]);
    assign chk_b = ((bus.r_in[6:5] ^ prev_q[4:3]) == prev_q[1:0]);

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        prev_d      = prev_q;
        good_d      = good_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        cnt_inc     = 1'b0;
        if (bus.en_dith) begin
            unique case (state_q)
                SEARCH: begin
                    prev_d  = bus.r_in;
                    state_d = ACQ;
                end
                ACQ: begin
                    if (chk_a && chk_b && (cand != '0)) begin
                        s_d     = cand;
                        good_d  = '0;
                        state_d = VERIFY;
                    end else begin
                        prev_d = bus.r_in;
                    end
                end
                VERIFY: begin
                    s_d = pred;
                    if (match) begin
                        good_d = good_q + CNT_W'(1);
                        if (good_d == CNT_W'(LOCK_GOOD)) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        state_d     = SEARCH;
                        err_pulse_d = 1'b1;
                    end
                end
                LOCKED: begin
                    // Prediction free-runs; r_in is only compared, never reloaded.
                    s_d = pred;
                    if (match) begin
                        bad_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        cnt_inc     = 1'b1;
                        bad_d       = bad_q + CNT_W'(1);
                        if (bad_d == CNT_W'(LOSS_THRESH)) begin
                            state_d = SEARCH;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= SEARCH;
            s_q         <= '0;
            prev_q      <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            prev_q      <= prev_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    ef_smsdac_satcnt #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr_i (bus.clr_cnt),
        .inc_i (cnt_inc),
        .cnt_o (err_cnt)
    );

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt;

endmodule
